// File: rtl/cmd_acmd_sequencer.sv
// Command sequencer in front of cmd_controller: prefixes application commands
// with CMD55 and polls ACMD41 until the card reports power-up done.
module cmd_acmd_sequencer #(
   parameter int MAX_RETRIES = 8,
   parameter int RETRY_GAP   = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_app,
   input  logic [5:0]  req_index,
   input  logic [31:0] req_argument,
   input  logic [15:0] rca,
   output logic        busy,
   output logic        done,
   output logic [1:0]  error_code,
   output logic [31:0] resp_out,
   output logic        ctrl_new_command,
   output logic [5:0]  ctrl_cmd_index,
   output logic [31:0] ctrl_cmd_argument,
   input  logic        ctrl_complete,
   input  logic        ctrl_timeout,
   input  logic [31:0] ctrl_response
);

   typedef enum logic [2:0] {
      S_IDLE, S_SEND55, S_WAIT55, S_SENDCMD, S_WAITCMD, S_GAP, S_FINISH
   } state_t;

   state_t      r_state, w_next;
   logic        r_req_app;
   logic [5:0]  r_req_index;
   logic [31:0] r_req_argument;
   logic [15:0] r_rca;
   logic [1:0]  r_error_code;
   logic [31:0] r_resp_out;
   logic [5:0]  r_cmd_index;
   logic [31:0] r_cmd_argument;
   logic [7:0]  r_retry;
   logic [15:0] r_gap_cnt;

   logic        w_accept;
   logic        w_not_ready;
   logic        w_retry_last;
   logic        w_gap_last;
   logic [7:0]  w_retry_inc;
   logic [5:0]  w_src_index;
   logic [31:0] w_src_argument;
   logic [15:0] w_src_rca;

   assign w_accept     = (r_state == S_IDLE) && req_valid;
   assign w_not_ready  = r_req_app && (r_req_index == 6'd41) && !ctrl_response[31];
   assign w_retry_inc  = r_retry + 8'd1;
   assign w_retry_last = (w_retry_inc == 8'(MAX_RETRIES));
   assign w_gap_last   = (r_gap_cnt == 16'(RETRY_GAP - 1));

   // On accept the request registers are still loading, so issue straight from the inputs.
   assign w_src_index    = w_accept ? req_index    : r_req_index;
   assign w_src_argument = w_accept ? req_argument : r_req_argument;
   assign w_src_rca      = w_accept ? rca          : r_rca;

   // NOTE: sequential state is updated only with non-blocking assignments.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // NOTE: w_next gets a default first, so no path can infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (req_valid) w_next = req_app ? S_SEND55 : S_SENDCMD;
         S_SEND55:  w_next = S_WAIT55;
         S_WAIT55: begin
            if (ctrl_timeout)       w_next = S_FINISH;
            else if (ctrl_complete) w_next = ctrl_response[5] ? S_SENDCMD : S_FINISH;
         end
         S_SENDCMD: w_next = S_WAITCMD;
         S_WAITCMD: begin
            if (ctrl_timeout)       w_next = S_FINISH;
            else if (ctrl_complete) w_next = (w_not_ready && !w_retry_last) ? S_GAP : S_FINISH;
         end
         S_GAP:     if (w_gap_last) w_next = S_SEND55;
         S_FINISH:  w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy             = 1'b0;
      done             = 1'b0;
      ctrl_new_command = 1'b0;
      case (r_state)
         S_SEND55, S_SENDCMD: begin
            busy             = 1'b1;
            ctrl_new_command = 1'b1;
         end
         S_WAIT55, S_WAITCMD, S_GAP: busy = 1'b1;
         S_FINISH: done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_req_app      <= 1'b0;
         r_req_index    <= 6'd0;
         r_req_argument <= 32'd0;
         r_rca          <= 16'd0;
         r_error_code   <= 2'd0;
         r_resp_out     <= 32'd0;
         r_cmd_index    <= 6'd0;
         r_cmd_argument <= 32'd0;
         r_retry        <= 8'd0;
         r_gap_cnt      <= 16'd0;
      end else begin
         if (w_accept) begin
            r_req_app      <= req_app;
            r_req_index    <= req_index;
            r_req_argument <= req_argument;
            r_rca          <= rca;
            r_error_code   <= 2'd0;
            r_retry        <= 8'd0;
         end

         // Timeout has priority over a simultaneous completion and leaves resp_out alone.
         case (r_state)
            S_WAIT55: begin
               if (ctrl_timeout) begin
                  r_error_code <= 2'd1;
               end else if (ctrl_complete) begin
                  r_resp_out <= ctrl_response;
                  if (!ctrl_response[5]) r_error_code <= 2'd2;
               end
            end
            S_WAITCMD: begin
               if (ctrl_timeout) begin
                  r_error_code <= 2'd1;
               end else if (ctrl_complete) begin
                  r_resp_out <= ctrl_response;
                  r_retry    <= w_retry_inc;
                  if (w_not_ready && w_retry_last) r_error_code <= 2'd3;
               end
            end
            default: ;
         endcase

         r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 16'd1 : 16'd0;

         if (w_next == S_SEND55) begin
            r_cmd_index    <= 6'd55;
            r_cmd_argument <= {w_src_rca, 16'h0000};
         end else if (w_next == S_SENDCMD) begin
            r_cmd_index    <= w_src_index;
            r_cmd_argument <= w_src_argument;
         end
      end
   end

   assign error_code        = r_error_code;
   assign resp_out          = r_resp_out;
   assign ctrl_cmd_index    = r_cmd_index;
   assign ctrl_cmd_argument = r_cmd_argument;

endmodule
